// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver (5-9 data bits, optional parity, 1 or 2 stop bits).
// Define UART_RX_MAJORITY_EN to take every sample as a 2-of-3 vote around the bit centre.
module uart_rx_param #(
  parameter int CLKS_PER_SAMPLE = 326,
  parameter int OVERSAMPLE      = 16,
  parameter int DATA_BITS       = 8,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_I,
  input  logic                 uart_REC_dataH,
  output logic                 rec_readyH,
  output logic [DATA_BITS-1:0] rec_dataH,
  output logic                 is_receiving,
  output logic                 frame_error,
  output logic                 parity_error
);

  localparam int CW  = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int MID = OVERSAMPLE / 2;

  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  // os_cnt holds the number of ticks seen in the bit so far, so the tick
  // carrying os_cnt == MID-1 is the MID-th tick after the start edge.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [OW-1:0] TAP0      = OW'(MID - 2);
  localparam logic [OW-1:0] TAP1      = OW'(MID - 1);
  localparam logic [OW-1:0] SAMPLE_AT = OW'(MID);
`else
  localparam logic [OW-1:0] SAMPLE_AT = OW'(MID - 1);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, RECOVER} state_t;

  state_t               state, next_state;
  logic                 rx_meta, rx_s;
  logic [CW-1:0]        clk_cnt;
  logic [OW-1:0]        os_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick, sample_ev, sample_val, start_edge, exp_par;
  logic                 frame_flag, par_flag;

  always_ff @(posedge sys_clk) begin
    if (sys_rst_I) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_REC_dataH;
      rx_s    <= rx_meta;
    end
  end

  assign start_edge = (state == IDLE) && !rx_s;
  assign tick       = (state != IDLE) && (clk_cnt == CLK_LAST);
  assign sample_ev  = tick && (os_cnt == SAMPLE_AT);
  assign exp_par    = (PARITY_MODE == 1) ? ~^shreg : ^shreg;

  // Holding both counters at zero in IDLE phase-aligns ticks to the detected edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_I || state == IDLE) begin
      clk_cnt <= '0;
      os_cnt  <= '0;
    end else begin
      clk_cnt <= (clk_cnt == CLK_LAST) ? '0 : clk_cnt + 1'b1;
      if (tick)
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic tap0, tap1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst_I) begin
      tap0 <= 1'b1;
      tap1 <= 1'b1;
    end else if (tick) begin
      if (os_cnt == TAP0) tap0 <= rx_s;
      if (os_cnt == TAP1) tap1 <= rx_s;
    end
  end

  assign sample_val = (tap0 & tap1) | (tap0 & rx_s) | (tap1 & rx_s);
`else
  assign sample_val = rx_s;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst_I) state <= IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_s) next_state = START;
      START:   if (sample_ev) next_state = sample_val ? IDLE : DATA;
      DATA:    if (sample_ev && bit_cnt == DATA_LAST)
                 next_state = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY:  if (sample_ev) next_state = STOP;
      STOP:    if (sample_ev && bit_cnt == STOP_LAST) next_state = DONE;
      DONE:    next_state = frame_flag ? RECOVER : IDLE;
      RECOVER: if (rx_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // bit_cnt indexes data bits, then is reused to count stop bits.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_I) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      frame_flag <= 1'b0;
      par_flag   <= 1'b0;
      rec_dataH  <= '0;
    end else begin
      if (start_edge) begin
        bit_cnt    <= '0;
        frame_flag <= 1'b0;
        par_flag   <= 1'b0;
      end else if (sample_ev) begin
        case (state)
          DATA: begin
            shreg   <= {sample_val, shreg[DATA_BITS-1:1]};
            bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
          end
          PARITY: par_flag <= (sample_val != exp_par);
          STOP: begin
            bit_cnt    <= bit_cnt + 1'b1;
            frame_flag <= frame_flag | !sample_val;
          end
          default: ;
        endcase
      end
      if (state == STOP && next_state == DONE)
        rec_dataH <= shreg;
    end
  end

  always_comb begin
    rec_readyH   = (state == DONE);
    frame_error  = (state == DONE) && frame_flag;
    parity_error = (state == DONE) && par_flag;
    is_receiving = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: randomized + directed bench for uart_rx_param (8N1 and 8E2 instances, 64-clock bits).
// Expected frames come from a bit-level model of the serial line and are matched against every rec_readyH pulse.
module tb_uart_rx_param;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic       rec_ready_a, busy_a, frame_err_a, parity_err_a;
  logic       rec_ready_b, busy_b, frame_err_b, parity_err_b;
  logic [7:0] rec_data_a, rec_data_b;

  int tests_run    = 0;
  int tests_failed = 0;

  // Each entry is {parity_error, frame_error, data}.
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  logic [9:0] mon_a, mon_b;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLKS_PER_SAMPLE(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)
  ) dut_a (
    .sys_clk(clk), .sys_rst_I(rst), .uart_REC_dataH(rx_a),
    .rec_readyH(rec_ready_a), .rec_dataH(rec_data_a), .is_receiving(busy_a),
    .frame_error(frame_err_a), .parity_error(parity_err_a)
  );

  uart_rx_param #(
    .CLKS_PER_SAMPLE(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)
  ) dut_b (
    .sys_clk(clk), .sys_rst_I(rst), .uart_REC_dataH(rx_b),
    .rec_readyH(rec_ready_b), .rec_dataH(rec_data_b), .is_receiving(busy_b),
    .frame_error(frame_err_b), .parity_error(parity_err_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setLine(input bit which, input logic v);
    if (which) rx_b = v;
    else       rx_a = v;
  endtask

  // Receiver outcome from line-level rules: even parity means an even count of
  // ones across data plus parity bit; any low stop bit is a framing error.
  function automatic logic [9:0] expectFrame(input bit which, input logic [7:0] data,
                                             input logic par_bit, input logic [1:0] stops);
    logic fe, pe;
    fe = which ? !(stops[0] && stops[1]) : !stops[0];
    pe = which ? (($countones({data, par_bit}) % 2) != 0) : 1'b0;
    return {pe, fe, data};
  endfunction

  // Drives one frame, starting just after a posedge; glitch_bit >= 0 puts a
  // one-clock high pulse on that data bit exactly at its single-sample point.
  task automatic applyStimulus(input bit which, input logic [7:0] data, input logic par_bit,
                               input logic [1:0] stops, input bit check_busy, input int glitch_bit);
    logic bits[$];
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (which) bits.push_back(par_bit);
    bits.push_back(stops[0]);
    if (which) bits.push_back(stops[1]);
    for (int k = 0; k < bits.size(); k++) begin
      setLine(which, bits[k]);
      repeat (BIT_CLKS / 2) @(posedge clk);
      if (glitch_bit >= 0 && k == glitch_bit + 1) begin
        setLine(which, 1'b1);
        @(posedge clk);
        setLine(which, bits[k]);
        repeat (BIT_CLKS / 2 - 1) @(posedge clk);
      end else begin
        if (check_busy) begin
          @(negedge clk);
          checkOutput($sformatf("busy_mid_bit%0d", k), which ? busy_b : busy_a, 1);
        end
        repeat (BIT_CLKS / 2) @(posedge clk);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rec_ready_a) begin
      if (exp_a.size() == 0) checkOutput("unexpected_ready_a", rec_ready_a, 0);
      else begin
        mon_a = exp_a.pop_front();
        checkOutput("data_a", rec_data_a, mon_a[7:0]);
        checkOutput("frame_err_a", frame_err_a, mon_a[8]);
        checkOutput("parity_err_a", parity_err_a, mon_a[9]);
      end
    end else if (frame_err_a || parity_err_a)
      checkOutput("stray_flag_a", {frame_err_a, parity_err_a}, 0);
  end

  always @(negedge clk) begin
    if (rec_ready_b) begin
      if (exp_b.size() == 0) checkOutput("unexpected_ready_b", rec_ready_b, 0);
      else begin
        mon_b = exp_b.pop_front();
        checkOutput("data_b", rec_data_b, mon_b[7:0]);
        checkOutput("frame_err_b", frame_err_b, mon_b[8]);
        checkOutput("parity_err_b", parity_err_b, mon_b[9]);
      end
    end else if (frame_err_b || parity_err_b)
      checkOutput("stray_flag_b", {frame_err_b, parity_err_b}, 0);
  end

  initial begin
    logic [7:0] data;
    logic       par_bit, err;
    logic [1:0] stops;
    int         gap;

    rst  = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready_a", rec_ready_a, 0);
    checkOutput("rst_data_a", rec_data_a, 0);
    checkOutput("rst_busy_a", busy_a, 0);
    checkOutput("rst_flags_a", {frame_err_a, parity_err_a}, 0);
    checkOutput("rst_ready_b", rec_ready_b, 0);
    checkOutput("rst_data_b", rec_data_b, 0);
    checkOutput("rst_busy_b", busy_b, 0);
    checkOutput("rst_flags_b", {frame_err_b, parity_err_b}, 0);
    @(posedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // Clean 8N1 frame, busy checked at every bit centre.
    exp_a.push_back(expectFrame(0, 8'hA5, 1'b0, 2'b11));
    applyStimulus(0, 8'hA5, 1'b0, 2'b11, 1, -1);
    @(negedge clk);
    checkOutput("idle_after_a5", busy_a, 0);
    checkOutput("hold_data_a5", rec_data_a, 8'hA5);
    repeat (10) @(posedge clk);

    // Even parity: 0x03 with parity 1 is wrong, with parity 0 is right.
    exp_b.push_back(expectFrame(1, 8'h03, 1'b1, 2'b11));
    applyStimulus(1, 8'h03, 1'b1, 2'b11, 1, -1);
    exp_b.push_back(expectFrame(1, 8'h03, 1'b0, 2'b11));
    applyStimulus(1, 8'h03, 1'b0, 2'b11, 0, -1);
    repeat (10) @(posedge clk);

    // Break: stop bit low, line then held low for five bit periods.
    exp_a.push_back(expectFrame(0, 8'h55, 1'b0, 2'b10));
    applyStimulus(0, 8'h55, 1'b0, 2'b10, 0, -1);
    repeat (5 * BIT_CLKS) @(posedge clk);
    @(negedge clk);
    checkOutput("busy_during_break", busy_a, 1);
    @(posedge clk);
    rx_a = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_after_break", busy_a, 0);
    repeat (20) @(posedge clk);

    // 20-clock low glitch on an idle line is rejected.
    rx_a = 1'b0;
    repeat (20) @(posedge clk);
    rx_a = 1'b1;
    repeat (44) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_after_glitch", busy_a, 0);
    repeat (64) @(posedge clk);
    exp_a.push_back(expectFrame(0, 8'h3C, 1'b0, 2'b11));
    applyStimulus(0, 8'h3C, 1'b0, 2'b11, 0, -1);
    repeat (10) @(posedge clk);

    // Reset in the middle of data bit 4 of 0x5A: no pulse, outputs cleared.
    data = 8'h5A;
    rx_a = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_a = data[i];
      repeat (BIT_CLKS) @(posedge clk);
    end
    rx_a = data[4];
    repeat (BIT_CLKS / 2) @(posedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_data_a", rec_data_a, 0);
    checkOutput("midrst_busy_a", busy_a, 0);
    checkOutput("midrst_ready_a", rec_ready_a, 0);
    rx_a = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    repeat (BIT_CLKS * 8) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_after_midrst", busy_a, 0);
    @(posedge clk);
    exp_a.push_back(expectFrame(0, 8'h81, 1'b0, 2'b11));
    applyStimulus(0, 8'h81, 1'b0, 2'b11, 0, -1);
    repeat (10) @(posedge clk);

    // One-clock high pulse on data bit 2 of 0x00: single sampling takes it, the vote rejects it.
`ifdef UART_RX_MAJORITY_EN
    exp_a.push_back({2'b00, 8'h00});
`else
    exp_a.push_back({2'b00, 8'h04});
`endif
    applyStimulus(0, 8'h00, 1'b0, 2'b11, 0, 2);
    repeat (10) @(posedge clk);

    // Random traffic on both receivers with occasional parity and stop errors.
    for (int n = 0; n < 24; n++) begin
      bit which;
      which   = n[0];
      data    = 8'($urandom);
      par_bit = (^data) ^ ($urandom_range(0, 3) == 0);
      err     = ($urandom_range(0, 5) == 0);
      stops   = err ? (which ? 2'($urandom_range(0, 2)) : 2'b10) : 2'b11;
      if (which) exp_b.push_back(expectFrame(1, data, par_bit, stops));
      else       exp_a.push_back(expectFrame(0, data, 1'b0, stops));
      applyStimulus(which, data, par_bit, stops, 0, -1);
      setLine(which, 1'b1);
      gap = err ? $urandom_range(8, 30) : $urandom_range(0, 20);
      repeat (gap) @(posedge clk);
    end

    repeat (200) @(posedge clk);
    checkOutput("pending_a", exp_a.size(), 0);
    checkOutput("pending_b", exp_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
